wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback stage;
  - the multi-cycle multiply/divide unit (MDU), which returns results out of step with the pipeline.
- Pipeline has normal priority. MDU results are held in a small FIFO and drain into idle write-port cycles.
- A starvation guard stalls the pipeline for one cycle when the FIFO head has waited too long.
- A pending-destination query port lets the hazard unit interlock on registers whose MDU write is still queued.

---
 rtl/wb_port_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The in-order pipeline writeback has
// normal priority. Results from the multiply/divide unit are queued in a
// small FIFO and written in cycles the pipeline leaves idle. A starvation
// guard stalls the pipeline for one cycle once the FIFO head has waited
// MAX_WAIT cycles. A query port reports whether a register still has a
// queued MDU write, so the hazard unit can interlock on it.
module wb_port_arbiter #(
   parameter int W        = 32,
   parameter int A        = 5,
   parameter int DEPTH    = 2,   // 2 or 4
   parameter int MAX_WAIT = 4    // 1..15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pipe_we,
   input  logic [A-1:0]           pipe_addr,
   input  logic [W-1:0]           pipe_data,
   input  logic                   mdu_valid,
   output logic                   mdu_ready,
   input  logic [A-1:0]           mdu_addr,
   input  logic [W-1:0]           mdu_data,
   output logic                   pipe_stall,
   input  logic [A-1:0]           query_addr,
   output logic                   query_pending,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   write_en,
   output logic [A-1:0]           reg_write_addr,
   output logic [W-1:0]           reg_write_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [A-1:0]     addr_q [DEPTH];
   logic [W-1:0]     data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_nxt;
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;
   logic [CW-1:0]    count_q;
   logic [3:0]       wait_q;

   logic             fifo_empty;
   logic             xfer;
   logic             push;
   logic             pop;
   logic             bypass;
   logic             sel_we;
   logic [A-1:0]     sel_addr;
   logic [W-1:0]     sel_data;

   // Handshake and stall depend on registered state only, so neither one
   // forms a combinational path back to the requesters.
   assign fifo_empty = (count_q == '0);
   assign mdu_ready  = (count_q != CW'(DEPTH));
   assign pipe_stall = !fifo_empty && (wait_q == 4'(MAX_WAIT));
   assign xfer       = mdu_valid && mdu_ready;
   assign fifo_count = count_q;

   // Write-port owner selection, highest priority first.
   always_comb begin
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      pop      = 1'b0;
      bypass   = 1'b0;
      if (pipe_stall || (!pipe_we && !fifo_empty)) begin
         pop      = 1'b1;
         sel_we   = 1'b1;
         sel_addr = addr_q[head_q];
         sel_data = data_q[head_q];
      end else if (pipe_we) begin
         // A write to r0 is consumed without touching the register file.
         if (pipe_addr != '0) begin
            sel_we   = 1'b1;
            sel_addr = pipe_addr;
            sel_data = pipe_data;
         end
      end else if (mdu_valid && (mdu_addr != '0)) begin
         // The FIFO is empty here, so mdu_ready is high and the result
         // can skip the queue entirely.
         bypass   = 1'b1;
         sel_we   = 1'b1;
         sel_addr = mdu_addr;
         sel_data = mdu_data;
      end
   end

   // Results for r0 complete the handshake but are never stored.
   assign push           = xfer && (mdu_addr != '0) && !bypass;
   assign write_en       = sel_we && rst;
   assign reg_write_addr = sel_addr;
   assign reg_write_data = sel_data;

   // Per-entry valid bits, kept so the query can scan the storage directly.
   always_comb begin
      valid_nxt = valid_q;
      if (pop) valid_nxt[head_q] = 1'b0;
      if (push) valid_nxt[tail_q] = 1'b1;
   end

   // Pending-destination lookup over the queued entries only.
   always_comb begin
      query_pending = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i] == query_addr)) query_pending = 1'b1;
      end
      if (query_addr == '0) query_pending = 1'b0;
   end

   // FIFO storage; contents need no reset because valid_q qualifies them.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= mdu_addr;
         data_q[tail_q] <= mdu_data;
      end
   end

   // Pointers, occupancy and head wait counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         wait_q  <= '0;
         valid_q <= '0;
      end else begin
         valid_q <= valid_nxt;
         if (push) tail_q <= tail_q + PW'(1);
         if (pop) head_q <= head_q + PW'(1);
         if (push && !pop) count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
         if (fifo_empty || pop) wait_q <= '0;
         else if (wait_q != 4'(MAX_WAIT)) wait_q <= wait_q + 4'd1;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the arbiter's rules.
module tb_wb_port_arbiter;

   localparam int W        = 32;
   localparam int A        = 5;
   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;

   typedef struct {
      logic [A-1:0] addr;
      logic [W-1:0] data;
   } ent_t;

   logic         clk;
   logic         rst;
   logic         pipe_we;
   logic [A-1:0] pipe_addr;
   logic [W-1:0] pipe_data;
   logic         mdu_valid;
   logic         mdu_ready;
   logic [A-1:0] mdu_addr;
   logic [W-1:0] mdu_data;
   logic         pipe_stall;
   logic [A-1:0] query_addr;
   logic         query_pending;
   logic [$clog2(DEPTH):0] fifo_count;
   logic         write_en;
   logic [A-1:0] reg_write_addr;
   logic [W-1:0] reg_write_data;

   int   total;
   int   bad;
   ent_t q[$];
   int   mw;
   bit   last_stall;
   bit   last_xfer;
   bit   obs_stall;
   int   k;

   wb_port_arbiter #(.W(W), .A(A), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
      .mdu_addr(mdu_addr), .mdu_data(mdu_data),
      .pipe_stall(pipe_stall),
      .query_addr(query_addr), .query_pending(query_pending),
      .fifo_count(fifo_count),
      .write_en(write_en), .reg_write_addr(reg_write_addr),
      .reg_write_data(reg_write_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs are already applied; check outputs against the
   // model, cross the edge, then advance the model.
   task automatic tick();
      bit           e_stall, e_ready, e_we, e_pop, e_byp, e_qp, chk_ad;
      logic [A-1:0] e_addr;
      logic [W-1:0] e_data;
      int           n;
      ent_t         e;
      #1;
      n       = q.size();
      e_stall = (n != 0) && (mw == MAX_WAIT);
      e_ready = (n != DEPTH);
      e_qp    = 1'b0;
      foreach (q[i]) if (query_addr != 0 && q[i].addr == query_addr) e_qp = 1'b1;
      e_we = 0; e_addr = '0; e_data = '0; e_pop = 0; e_byp = 0; chk_ad = 1;
      if (e_stall || (!pipe_we && n != 0)) begin
         e_pop = 1; e_we = 1; e_addr = q[0].addr; e_data = q[0].data;
      end else if (pipe_we) begin
         if (pipe_addr != 0) begin
            e_we = 1; e_addr = pipe_addr; e_data = pipe_data;
         end else begin
            chk_ad = 0;
         end
      end else if (mdu_valid && mdu_addr != 0) begin
         e_byp = 1; e_we = 1; e_addr = mdu_addr; e_data = mdu_data;
      end
      obs_stall = pipe_stall;
      chk("pipe_stall", W'(pipe_stall), W'(e_stall));
      chk("mdu_ready", W'(mdu_ready), W'(e_ready));
      chk("fifo_count", W'(fifo_count), W'(n));
      chk("query_pending", W'(query_pending), W'(e_qp));
      chk("write_en", W'(write_en), W'(e_we));
      if (chk_ad) begin
         chk("write_addr", W'(reg_write_addr), W'(e_addr));
         chk("write_data", reg_write_data, e_data);
      end
      @(posedge clk);
      #1;
      last_stall = e_stall;
      last_xfer  = mdu_valid && e_ready;
      if (e_pop) void'(q.pop_front());
      if (last_xfer && mdu_addr != 0 && !e_byp) begin
         e.addr = mdu_addr;
         e.data = mdu_data;
         q.push_back(e);
      end
      if (n == 0 || e_pop) mw = 0;
      else if (mw < MAX_WAIT) mw = mw + 1;
   endtask

   task automatic set_pipe(input logic we, input logic [A-1:0] a, input logic [W-1:0] d);
      pipe_we = we; pipe_addr = a; pipe_data = d;
   endtask

   task automatic set_mdu(input logic v, input logic [A-1:0] a, input logic [W-1:0] d);
      mdu_valid = v; mdu_addr = a; mdu_data = d;
   endtask

   task automatic drain();
      set_pipe(0, 0, 0);
      set_mdu(0, 0, 0);
      for (int i = 0; i < 8 && q.size() != 0; i++) tick();
      chk("drain_empty", W'(q.size()), 0);
   endtask

   initial begin
      total = 0; bad = 0; mw = 0; last_stall = 0; last_xfer = 0;
      rst = 1'b0;
      set_pipe(0, 0, 0);
      set_mdu(0, 0, 0);
      query_addr = '0;

      // Reset state
      #2;
      chk("rst_write_en", W'(write_en), 0);
      chk("rst_count", W'(fifo_count), 0);
      chk("rst_ready", W'(mdu_ready), 1);
      chk("rst_stall", W'(pipe_stall), 0);
      chk("rst_query", W'(query_pending), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Bypass: empty FIFO, idle pipeline
      set_mdu(1, 7, 32'hDEAD_BEEF);
      tick();
      set_mdu(0, 0, 0);
      tick();

      // Priority and queueing under continuous pipeline writes
      set_pipe(1, 10, 32'h0000_AAAA);
      set_mdu(1, 3, 32'h0000_0333);
      tick();
      set_mdu(1, 4, 32'h0000_0444);
      tick();
      set_mdu(1, 6, 32'h0000_0666);
      query_addr = 4;
      tick();
      query_addr = 5;
      tick();
      query_addr = 3;
      for (int i = 0; i < 6; i++) tick();
      set_mdu(0, 0, 0);
      query_addr = 0;

      // Drain: pipeline goes idle with entries queued
      set_mdu(1, 11, 32'h0000_0B0B);
      tick();
      set_mdu(0, 0, 0);
      set_pipe(0, 0, 0);
      for (int i = 0; i < 3; i++) tick();
      drain();

      // Zero register on both requesters
      set_pipe(1, 0, 32'h0BAD_0BAD);
      tick();
      set_pipe(0, 0, 0);
      set_mdu(1, 0, 32'h0000_F00D);
      tick();
      set_mdu(0, 0, 0);
      tick();

      // Starvation: count cycles from the push until the stall
      set_pipe(1, 9, 32'h0000_1234);
      set_mdu(1, 12, 32'h0000_5555);
      tick();
      set_mdu(0, 0, 0);
      k = 0;
      obs_stall = 0;
      while (!obs_stall && k < 20) begin
         k++;
         tick();
      end
      chk("stall_cycle", W'(k), 5);
      tick();
      chk("held_pipe_write_addr", W'(reg_write_addr), 9);
      set_pipe(0, 0, 0);
      drain();

      // Reset mid-traffic with two entries queued
      set_pipe(1, 13, 32'h0000_1313);
      set_mdu(1, 14, 32'h0000_1414);
      tick();
      set_mdu(1, 15, 32'h0000_1515);
      tick();
      set_mdu(0, 0, 0);
      query_addr = 14;
      chk("pre_rst_queued", W'(q.size()), 2);
      rst = 1'b0;
      #1;
      chk("mid_rst_write_en", W'(write_en), 0);
      chk("mid_rst_count", W'(fifo_count), 0);
      chk("mid_rst_ready", W'(mdu_ready), 1);
      chk("mid_rst_query", W'(query_pending), 0);
      q.delete();
      mw = 0;
      @(posedge clk); #1;
      chk("mid_rst_write_en2", W'(write_en), 0);
      rst = 1'b1;
      set_pipe(0, 0, 0);
      for (int i = 0; i < 4; i++) tick();

      // Random traffic with protocol-correct holding on both requesters
      last_stall = 0;
      last_xfer  = 0;
      set_mdu(0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) begin
            set_pipe(($urandom_range(0, 9) < 6), A'($urandom_range(0, 7)), $urandom);
         end
         if (!mdu_valid || last_xfer) begin
            set_mdu(($urandom_range(0, 9) < 5), A'($urandom_range(0, 7)), $urandom);
         end
         query_addr = A'($urandom_range(0, 7));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
